cache_dm_line: RTL
==================

Name: cache_dm_line

Overview:
- Parametrised successor to the single-word direct-mapped data cache in the MIPS processor memory path.
- Sits between the datapath load/store port and main memory.
- Adds multi-word lines, a real fill state machine with a memory request/ack handshake, write-through with no-write-allocate, and asynchronous reset of all valid bits.

Parameters:
SETS, 32, number of lines; power of two, 2..256
LINE_WORDS, 4, 32-bit words per line; power of two, 1..16
(derived) OFF_W = log2(LINE_WORDS), IDX_W = log2(SETS), TAG_W = 30 - OFF_W - IDX_W

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpuRead  input  1  load request; held until cpuReady
cpuWrite  input  1  store request; held until cpuReady
cpuAddr  input  32  byte address; bits [1:0] ignored
cpuWriteData  input  32  store data
cpuReadData  output  32  load data; valid when cpuReady && cpuRead
cpuReady  output  1  request complete this cycle (1-cycle pulse per request)
memRead  output  1  memory word read request
memWrite  output  1  memory word write request
memAddr  output  32  word-aligned memory address
memWriteData  output  32  memory write data
memReadData  input  32  valid in cycle memReady=1 for a read
memReady  input  1  memory ack; one pulse completes one word transfer
statReads  output  32  load request count (see Optional Feature)
statMisses  output  32  load miss count (see Optional Feature)

Behaviour:
- Address split: tag = cpuAddr[31:2+OFF_W+IDX_W], index = cpuAddr[2+OFF_W+IDX_W-1:2+OFF_W], offset = cpuAddr[2+OFF_W-1:2].
- Storage per set: valid bit, TAG_W tag, LINE_WORDS x 32 data.
- Reset (async, rst_n=0): all valid bits = 0, state = IDLE, fill counter = 0.
  - All outputs 0: cpuReady, cpuReadData, memRead, memWrite, memAddr, memWriteData.
  - Data and tag arrays are not cleared.
- State machine: IDLE, FILL, WRITE.
- IDLE:
  - cpuWrite=1 (priority over cpuRead if both asserted) -> WRITE.
  - Else cpuRead=1 and hit (valid && tag match):
    - cpuReady=1 combinationally, same cycle.
    - cpuReadData = line[offset].
    - Zero-cycle hit latency.
  - Else cpuRead=1 and miss -> FILL, fill counter = 0.
- FILL:
  - memRead=1.
  - memAddr = {tag, index, counter, 2'b00}; fills words in ascending order from word 0.
  - On memReady: write memReadData into line[counter], then increment counter.
  - On memReady with counter = LINE_WORDS-1: set valid, write tag, return to IDLE.
  - The held request then hits on the next cycle.
  - Miss latency = sum of memory word latencies + 1 cycle.
  - memRead stays 1 across consecutive words; memAddr changes the cycle after each memReady.
- WRITE (write-through, no-write-allocate):
  - memWrite=1, memAddr = {cpuAddr[31:2], 2'b00}, memWriteData = cpuWriteData.
  - On memReady: cpuReady=1 that cycle and state -> IDLE.
  - If the line hits, update line[offset] in the same edge.
  - On miss, the array is unchanged.
- Requests are sampled only in IDLE. cpuAddr and cpuWriteData must be stable until cpuReady; the bench flags violations.
- A memReady while neither memRead nor memWrite is asserted is ignored.
- Reset mid-FILL: fill abandoned, line left invalid, memRead deasserts asynchronously.
- Reset mid-WRITE: memory write is abandoned, no cpuReady.
- No CPU request in IDLE: all mem* outputs 0, cpuReady 0.

Optional Feature:
Macro CACHE_DM_STATS_EN.
- Defined:
  - statReads increments once per completed load, on the cpuReady edge.
  - statMisses increments once per FILL entry.
  - Both are 32-bit saturating at 32'hFFFFFFFF and cleared by rst_n.
- Undefined: statReads and statMisses tied to 0, no counter flops synthesised. Ports remain present so the top level is unchanged.

Test Plan:
- Cold miss, SETS=32, LINE_WORDS=4, memReady 2 cycles after each request; load 0x0000_0040:
  - Exactly 4 memRead words, at 0x40, 0x44, 0x48, 0x4C.
  - cpuReady on cycle 13 with memory data.
  - statMisses=1.
- After the fill above, load 0x0000_0048 -> cpuReady same cycle, no memRead, data = word 2 of the fill.
- Conflict miss: load 0x0000_0040, then load 0x0000_0840 (same index, new tag) -> second load refills, then 0x0000_0040 misses again; statMisses=3, statReads=3.
- Store 0xDEADBEEF to 0x0000_0044 on a resident line -> memWrite at 0x44; subsequent load 0x44 hits and returns 0xDEADBEEF.
  - Store to a non-resident address -> memWrite only; the following load of that address misses.
- Assert rst_n=0 during the 3rd fill word -> memRead drops immediately; after release, the same load refetches all 4 words.
- cpuRead=cpuWrite=1 to 0x0000_0100 -> treated as a store; memWrite asserted, memRead never asserted.

Source files
------------

// File: rtl/cache_dm_line_if.sv
// rtl/cache_dm_line_if.sv - CPU load/store and memory word ports of cache_dm_line
interface cache_dm_line_if;
  logic        cpuRead;
  logic        cpuWrite;
  logic [31:0] cpuAddr;
  logic [31:0] cpuWriteData;
  logic [31:0] cpuReadData;
  logic        cpuReady;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memReady;
  logic [31:0] statReads;
  logic [31:0] statMisses;

  modport slave (
    input  cpuRead, cpuWrite, cpuAddr, cpuWriteData, memReadData, memReady,
    output cpuReadData, cpuReady, memRead, memWrite, memAddr, memWriteData,
           statReads, statMisses
  );

  modport master (
    output cpuRead, cpuWrite, cpuAddr, cpuWriteData, memReadData, memReady,
    input  cpuReadData, cpuReady, memRead, memWrite, memAddr, memWriteData,
           statReads, statMisses
  );
endinterface

// File: rtl/cache_dm_line.sv
// rtl/cache_dm_line.sv - direct-mapped write-through, no-write-allocate line cache
// Optional load/miss counters enabled by CACHE_DM_STATS_EN
module cache_dm_line #(
  parameter int SETS       = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  cache_dm_line_if.slave bus
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam int CNT_W = (OFF_W == 0) ? 1 : OFF_W;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
  localparam logic [29:0] OFF_MASK = 30'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][LINE_WORDS];

  logic [29:0]      word_addr;
  logic [29:0]      fill_word;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] off;
  logic             hit;
  logic             load_hit;
  logic             load_miss;
  logic             last_word;

  assign word_addr = bus.cpuAddr[31:2];
  assign tag       = word_addr[29 -: TAG_W];
  assign idx       = word_addr[OFF_W +: IDX_W];
  assign off       = CNT_W'(word_addr & OFF_MASK);
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  // Stores win over loads when both are raised in the same cycle.
  assign load_hit  = (state == IDLE) && bus.cpuRead && !bus.cpuWrite && hit;
  assign load_miss = (state == IDLE) && bus.cpuRead && !bus.cpuWrite && !hit;
  assign fill_word = (word_addr & ~OFF_MASK) | 30'(cnt);
  assign last_word = (cnt == LAST_WORD);

  always_comb begin
    bus.cpuReady     = 1'b0;
    bus.cpuReadData  = '0;
    bus.memRead      = 1'b0;
    bus.memWrite     = 1'b0;
    bus.memAddr      = '0;
    bus.memWriteData = '0;
    case (state)
      IDLE: begin
        if (load_hit) begin
          bus.cpuReady    = 1'b1;
          bus.cpuReadData = data_q[idx][off];
        end
      end
      FILL: begin
        bus.memRead = 1'b1;
        bus.memAddr = {fill_word, 2'b00};
      end
      WRITE: begin
        bus.memWrite     = 1'b1;
        bus.memAddr      = {word_addr, 2'b00};
        bus.memWriteData = bus.cpuWriteData;
        bus.cpuReady     = bus.memReady;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpuWrite) begin
            state <= WRITE;
          end else if (load_miss) begin
            state        <= FILL;
            cnt          <= '0;
            valid_q[idx] <= 1'b0;
          end
        end
        FILL: begin
          if (bus.memReady) begin
            cnt <= cnt + 1'b1;
            if (last_word) begin
              valid_q[idx] <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        WRITE: begin
          if (bus.memReady) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Arrays are deliberately not reset; only the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == FILL && bus.memReady) begin
      data_q[idx][cnt] <= bus.memReadData;
      if (last_word) tag_q[idx] <= tag;
    end
    if (state == WRITE && bus.memReady && hit) data_q[idx][off] <= bus.cpuWriteData;
  end

`ifdef CACHE_DM_STATS_EN
  logic [31:0] reads_q;
  logic [31:0] misses_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reads_q  <= '0;
      misses_q <= '0;
    end else begin
      if (load_hit && reads_q != 32'hFFFF_FFFF) reads_q <= reads_q + 32'd1;
      if (load_miss && misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
    end
  end

  assign bus.statReads  = reads_q;
  assign bus.statMisses = misses_q;
`else
  assign bus.statReads  = '0;
  assign bus.statMisses = '0;
`endif
endmodule
